// File: rtl/key_debounce_repeat.sv
// Key conditioning: 2-flop sync, debounce, press/release strobes and
// auto-repeat, one fully independent lane per key.

module key_debounce_repeat_lane #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);
    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DLY_LAST = TW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    logic [1:0]    r_sync;
    logic [DW-1:0] r_cnt;
    logic          r_pressed;
    logic          r_press_pulse;
    logic          r_release_pulse;
    logic          r_repeat_pulse;
    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;

    logic w_raw;
    logic w_accept;

    assign w_raw    = ~r_sync[1];
    // New level accepted on the last of DEBOUNCE_CYCLES consecutive differing cycles
    assign w_accept = (w_raw != r_pressed) && (r_cnt == CNT_LAST);

    // Two-flop synchronizer; resets to the released level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], key_n};
    end

    // Debounce counter: counts consecutive cycles the synced level differs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_pressed <= 1'b0;
        end else if (w_raw == r_pressed) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_pressed <= w_raw;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Edge strobes, registered alongside the level so they share its first cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_press_pulse   <= w_accept &  w_raw;
            r_release_pulse <= w_accept & ~w_raw;
        end
    end

    // Auto-repeat FSM; a release acceptance overrides any pending repeat slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_repeat_pulse <= 1'b0;
        end else begin
            r_repeat_pulse <= 1'b0;
            if (w_accept && !w_raw) begin
                r_state <= S_IDLE;
                r_timer <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_timer <= '0;
                        if (w_accept && w_raw && (REPEAT_DELAY > 0)) r_state <= S_DELAY;
                    end
                    S_DELAY: begin
                        if (r_timer == DLY_LAST) begin
                            r_repeat_pulse <= 1'b1;
                            r_state        <= S_REPEAT;
                            r_timer        <= '0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    S_REPEAT: begin
                        if (r_timer == PER_LAST) begin
                            r_repeat_pulse <= 1'b1;
                            r_timer        <= '0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_timer <= '0;
                    end
                endcase
            end
        end
    end

    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign repeat_pulse  = r_repeat_pulse;
endmodule

module key_debounce_repeat #(
    parameter int W               = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] key_n,
    output logic [W-1:0] pressed,
    output logic [W-1:0] press_pulse,
    output logic [W-1:0] release_pulse,
    output logic [W-1:0] repeat_pulse
);
    for (genvar g = 0; g < W; g++) begin : g_lane
        key_debounce_repeat_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_lane (
            .clk           (clk),
            .reset_n       (reset_n),
            .key_n         (key_n[g]),
            .pressed       (pressed[g]),
            .press_pulse   (press_pulse[g]),
            .release_pulse (release_pulse[g]),
            .repeat_pulse  (repeat_pulse[g])
        );
    end
endmodule
